keypad_entry: RTL and testbench

- Sequential successor to the combinational key decoder. Sits between the keypad scanner and the calculator ALU/controller.
- Rising-edge-detects the key strobe and accumulates decimal digits into a signed binary operand with optional unary minus.
- On operator, execute or clear keys, emits one buffered event over a valid/ready handshake.
- Parametrised in operand width, digit capacity and negative-entry support.

---
 rtl/keypad_entry.sv | 164 ++++++++++++++++
 tb/tb_keypad_entry.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Keypad digit accumulator: edge-detected keys build a signed operand; operator/execute/clear keys
// emit one event through a single-entry valid/ready buffer (event visible the cycle after the key edge).
module keypad_entry #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int ALLOW_NEG  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 keystrobe,
    input  logic [3:0]                           keycode,
    input  logic                                 ev_ready,
    output logic                                 ev_valid,
    output logic [1:0]                           ev_kind,
    output logic [1:0]                           ev_op,
    output logic                                 ev_has_operand,
    output logic [WIDTH-1:0]                     ev_value,
    output logic [WIDTH-1:0]                     entry_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      entry_digits,
    output logic                                 entry_neg,
    output logic                                 key_drop
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0] MAXD = DW'(MAX_DIGITS);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int MIN_W = $clog2(pow10(MAX_DIGITS)) + 1;

    generate
        if (WIDTH < MIN_W) begin : g_width_check
            $error("keypad_entry: WIDTH too small to hold MAX_DIGITS decimal digits plus sign");
        end
    endgenerate

    localparam logic [1:0] KIND_OP    = 2'd0;
    localparam logic [1:0] KIND_EXEC  = 2'd1;
    localparam logic [1:0] KIND_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        NEG   = 2'd1,
        ENTRY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              strobe_q;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [DW-1:0]     digits_q, digits_d;
    logic              neg_q, neg_d;
    logic              ev_valid_q, ev_valid_d;
    logic [1:0]        ev_kind_q, ev_kind_d;
    logic [1:0]        ev_op_q, ev_op_d;
    logic              ev_has_q, ev_has_d;
    logic [WIDTH-1:0]  ev_value_q, ev_value_d;
    logic              drop_q, drop_d;

    logic              key_ev;
    logic              buf_free;
    logic              neg_toggle;
    logic [WIDTH-1:0]  signed_mag;

    assign key_ev     = keystrobe & ~strobe_q;
    assign buf_free   = ~ev_valid_q | ev_ready;
    assign signed_mag = neg_q ? -mag_q : mag_q;
    // Subtract only acts as a sign key before any digit has been entered.
    assign neg_toggle = (ALLOW_NEG != 0) && (keycode == 4'd14) && (state_q != ENTRY);

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        digits_d   = digits_q;
        neg_d      = neg_q;
        ev_valid_d = ev_valid_q & ~ev_ready;
        ev_kind_d  = ev_kind_q;
        ev_op_d    = ev_op_q;
        ev_has_d   = ev_has_q;
        ev_value_d = ev_value_q;
        drop_d     = 1'b0;

        if (key_ev) begin
            if (keycode <= 4'd9) begin
                if (state_q != ENTRY) begin
                    state_d  = ENTRY;
                    mag_d    = WIDTH'(keycode);
                    digits_d = (keycode != 4'd0) ? DW'(1) : '0;
                end else if (digits_q < MAXD) begin
                    mag_d = (mag_q << 3) + (mag_q << 1) + WIDTH'(keycode);
                    if (!(mag_q == '0 && keycode == 4'd0)) digits_d = digits_q + 1'b1;
                end
            end else if (keycode == 4'd10) begin
                state_d    = EMPTY;
                mag_d      = '0;
                digits_d   = '0;
                neg_d      = 1'b0;
                ev_valid_d = 1'b1;
                ev_kind_d  = KIND_CLEAR;
                ev_op_d    = 2'd0;
                ev_has_d   = 1'b0;
                ev_value_d = '0;
            end else if (neg_toggle) begin
                state_d = (state_q == EMPTY) ? NEG : EMPTY;
                neg_d   = (state_q == EMPTY);
            end else if (buf_free) begin
                ev_valid_d = 1'b1;
                ev_kind_d  = (keycode == 4'd11) ? KIND_EXEC : KIND_OP;
                ev_op_d    = (keycode == 4'd11) ? 2'd0 : ~keycode[1:0];
                ev_has_d   = (state_q == ENTRY);
                ev_value_d = (state_q == ENTRY) ? signed_mag : '0;
                state_d    = EMPTY;
                mag_d      = '0;
                digits_d   = '0;
                neg_d      = 1'b0;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            strobe_q   <= 1'b0;
            mag_q      <= '0;
            digits_q   <= '0;
            neg_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_kind_q  <= 2'd0;
            ev_op_q    <= 2'd0;
            ev_has_q   <= 1'b0;
            ev_value_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            strobe_q   <= keystrobe;
            mag_q      <= mag_d;
            digits_q   <= digits_d;
            neg_q      <= neg_d;
            ev_valid_q <= ev_valid_d;
            ev_kind_q  <= ev_kind_d;
            ev_op_q    <= ev_op_d;
            ev_has_q   <= ev_has_d;
            ev_value_q <= ev_value_d;
            drop_q     <= drop_d;
        end
    end

    assign ev_valid       = ev_valid_q;
    assign ev_kind        = ev_kind_q;
    assign ev_op          = ev_op_q;
    assign ev_has_operand = ev_has_q;
    assign ev_value       = ev_value_q;
    assign entry_value    = signed_mag;
    assign entry_digits   = digits_q;
    assign entry_neg      = neg_q;
    assign key_drop       = drop_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random keys checked against a digit-list model.
module tb_keypad_entry;

    localparam int WIDTH      = 16;
    localparam int MAX_DIGITS = 4;
    localparam int ALLOW_NEG  = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              keystrobe = 1'b0;
    logic [3:0]        keycode = 4'd0;
    logic              ev_ready = 1'b1;
    logic              ev_valid;
    logic [1:0]        ev_kind;
    logic [1:0]        ev_op;
    logic              ev_has_operand;
    logic [WIDTH-1:0]  ev_value;
    logic [WIDTH-1:0]  entry_value;
    logic [2:0]        entry_digits;
    logic              entry_neg;
    logic              key_drop;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .ALLOW_NEG(ALLOW_NEG)) dut (
        .clk(clk), .rst_n(rst_n), .keystrobe(keystrobe), .keycode(keycode), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_op(ev_op), .ev_has_operand(ev_has_operand),
        .ev_value(ev_value), .entry_value(entry_value), .entry_digits(entry_digits),
        .entry_neg(entry_neg), .key_drop(key_drop)
    );

    always #5 clk = ~clk;

    // Reference model: the operand is the list of significant digits typed so far.
    bit m_prev, m_started, m_minus, m_pend, m_has, m_drop;
    int m_digs[$];
    int m_kind, m_op, m_val;

    function automatic int model_mag();
        int v = 0;
        foreach (m_digs[i]) v = v * 10 + m_digs[i];
        return v;
    endfunction

    task automatic model_clear_entry();
        m_started = 0; m_minus = 0; m_digs.delete();
    endtask

    task automatic model_reset();
        model_clear_entry();
        m_prev = 0; m_pend = 0; m_has = 0; m_drop = 0; m_kind = 0; m_op = 0; m_val = 0;
    endtask

    task automatic model_step();
        bit nxt_pend;
        bit drop;
        int kc;
        kc = int'(keycode);
        nxt_pend = m_pend && !ev_ready;
        drop = 0;
        if (keystrobe && !m_prev) begin
            if (kc <= 9) begin
                if (!m_started) begin
                    m_started = 1;
                    m_digs.delete();
                    if (kc != 0) m_digs.push_back(kc);
                end else if (m_digs.size() < MAX_DIGITS && !(m_digs.size() == 0 && kc == 0)) begin
                    m_digs.push_back(kc);
                end
            end else if (kc == 10) begin
                model_clear_entry();
                nxt_pend = 1; m_kind = 2; m_op = 0; m_has = 0; m_val = 0;
            end else if (kc == 14 && ALLOW_NEG != 0 && !m_started) begin
                m_minus = !m_minus;
            end else if (!m_pend || ev_ready) begin
                nxt_pend = 1;
                m_kind = (kc == 11) ? 1 : 0;
                m_op = (kc == 11) ? 0 : 15 - kc;
                m_has = m_started;
                m_val = m_started ? (m_minus ? -model_mag() : model_mag()) : 0;
                model_clear_entry();
            end else begin
                drop = 1;
            end
        end
        m_prev = keystrobe; m_pend = nxt_pend; m_drop = drop;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic key_down(input int code);
        keystrobe = 1'b1; keycode = 4'(code); tick();
    endtask

    task automatic key_up();
        keystrobe = 1'b0; tick();
    endtask

    task automatic press(input int code);
        key_down(code); key_up();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; keystrobe = 1'b0; ev_ready = 1'b1;
        model_reset();
        #12;
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ev_valid got %0b want 0", ev_valid); end
        n_cmp++; if (entry_value !== 16'd0) begin n_bad++; $display("FAIL reset_entry_value got %0h want 0", entry_value); end
        n_cmp++; if (entry_digits !== 3'd0) begin n_bad++; $display("FAIL reset_entry_digits got %0d want 0", entry_digits); end
        n_cmp++; if (entry_neg !== 1'b0 || key_drop !== 1'b0) begin n_bad++; $display("FAIL reset_flags got neg=%0b drop=%0b want 0 0", entry_neg, key_drop); end
        n_cmp++; if (ev_kind !== 2'd0 || ev_op !== 2'd0 || ev_has_operand !== 1'b0 || ev_value !== 16'd0) begin
            n_bad++; $display("FAIL reset_payload got kind=%0d op=%0d has=%0b val=%0h want all 0", ev_kind, ev_op, ev_has_operand, ev_value); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ev_valid !== 1'b0 || entry_value !== 16'd0) begin n_bad++; $display("FAIL post_reset got valid=%0b entry=%0h want 0 0", ev_valid, entry_value); end
    endtask

    task automatic test_add();
        ev_ready = 1'b1;
        press(1); press(2); press(3);
        n_cmp++; if (entry_value !== 16'd123 || entry_digits !== 3'd3) begin n_bad++; $display("FAIL add_entry got %0d/%0d want 123/3", entry_value, entry_digits); end
        key_down(15);
        n_cmp++; if (ev_valid !== 1'b1 || ev_kind !== 2'd0 || ev_op !== 2'd0) begin n_bad++; $display("FAIL add_event got v=%0b k=%0d op=%0d want 1 0 0", ev_valid, ev_kind, ev_op); end
        n_cmp++; if (ev_has_operand !== 1'b1 || ev_value !== 16'd123) begin n_bad++; $display("FAIL add_value got has=%0b val=%0d want 1 123", ev_has_operand, ev_value); end
        n_cmp++; if (entry_digits !== 3'd0 || entry_value !== 16'd0) begin n_bad++; $display("FAIL add_entry_reset got %0d/%0d want 0/0", entry_digits, entry_value); end
        key_up();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL add_consumed got %0b want 0", ev_valid); end
    endtask

    task automatic test_negative();
        ev_ready = 1'b1;
        press(14);
        n_cmp++; if (entry_neg !== 1'b1 || entry_value !== 16'd0 || ev_valid !== 1'b0) begin n_bad++; $display("FAIL neg_pending got neg=%0b val=%0h v=%0b want 1 0 0", entry_neg, entry_value, ev_valid); end
        press(4); press(5);
        n_cmp++; if (entry_value !== 16'hFFD3 || entry_neg !== 1'b1) begin n_bad++; $display("FAIL neg_entry got %0h neg=%0b want ffd3 1", entry_value, entry_neg); end
        key_down(11);
        n_cmp++; if (ev_kind !== 2'd1 || ev_value !== 16'hFFD3 || ev_has_operand !== 1'b1 || ev_op !== 2'd0) begin
            n_bad++; $display("FAIL neg_exec got k=%0d val=%0h has=%0b op=%0d want 1 ffd3 1 0", ev_kind, ev_value, ev_has_operand, ev_op); end
        n_cmp++; if (entry_neg !== 1'b0) begin n_bad++; $display("FAIL neg_cleared got %0b want 0", entry_neg); end
        key_up();
        press(14);
        press(14);
        n_cmp++; if (entry_neg !== 1'b0 || ev_valid !== 1'b0) begin n_bad++; $display("FAIL neg_toggle_back got neg=%0b v=%0b want 0 0", entry_neg, ev_valid); end
    endtask

    task automatic test_saturate();
        ev_ready = 1'b1;
        for (int d = 1; d <= 5; d++) press(d);
        n_cmp++; if (entry_value !== 16'd1234 || entry_digits !== 3'd4) begin n_bad++; $display("FAIL sat_entry got %0d/%0d want 1234/4", entry_value, entry_digits); end
        key_down(11);
        n_cmp++; if (ev_value !== 16'd1234 || ev_kind !== 2'd1) begin n_bad++; $display("FAIL sat_exec got %0d k=%0d want 1234 1", ev_value, ev_kind); end
        key_up();
        press(3);
        keystrobe = 1'b1; keycode = 4'd7;
        for (int i = 0; i < 10; i++) tick();
        key_up();
        n_cmp++; if (entry_value !== 16'd37 || entry_digits !== 3'd2) begin n_bad++; $display("FAIL held_strobe got %0d/%0d want 37/2", entry_value, entry_digits); end
        press(10);
    endtask

    task automatic test_backpressure();
        ev_ready = 1'b0;
        press(1);
        key_down(13);
        n_cmp++; if (ev_valid !== 1'b1 || ev_op !== 2'd2 || ev_value !== 16'd1) begin n_bad++; $display("FAIL bp_first got v=%0b op=%0d val=%0d want 1 2 1", ev_valid, ev_op, ev_value); end
        key_up();
        press(2);
        key_down(12);
        n_cmp++; if (key_drop !== 1'b1) begin n_bad++; $display("FAIL bp_drop got %0b want 1", key_drop); end
        n_cmp++; if (ev_op !== 2'd2 || ev_value !== 16'd1 || ev_valid !== 1'b1) begin n_bad++; $display("FAIL bp_stable got op=%0d val=%0d v=%0b want 2 1 1", ev_op, ev_value, ev_valid); end
        n_cmp++; if (entry_value !== 16'd2 || entry_digits !== 3'd1) begin n_bad++; $display("FAIL bp_entry_kept got %0d/%0d want 2/1", entry_value, entry_digits); end
        key_up();
        n_cmp++; if (key_drop !== 1'b0) begin n_bad++; $display("FAIL bp_drop_pulse got %0b want 0", key_drop); end
        ev_ready = 1'b1;
        key_down(12);
        n_cmp++; if (ev_valid !== 1'b1 || ev_op !== 2'd3 || ev_value !== 16'd2 || key_drop !== 1'b0) begin
            n_bad++; $display("FAIL bp_second got v=%0b op=%0d val=%0d drop=%0b want 1 3 2 0", ev_valid, ev_op, ev_value, key_drop); end
        key_up();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %0b want 0", ev_valid); end
    endtask

    task automatic test_clear_override();
        ev_ready = 1'b0;
        press(3);
        key_down(15);
        key_up();
        press(8);
        key_down(10);
        n_cmp++; if (ev_valid !== 1'b1 || ev_kind !== 2'd2 || ev_has_operand !== 1'b0 || ev_value !== 16'd0) begin
            n_bad++; $display("FAIL clr_payload got v=%0b k=%0d has=%0b val=%0h want 1 2 0 0", ev_valid, ev_kind, ev_has_operand, ev_value); end
        n_cmp++; if (key_drop !== 1'b0 || entry_value !== 16'd0 || entry_digits !== 3'd0) begin
            n_bad++; $display("FAIL clr_entry got drop=%0b entry=%0h dig=%0d want 0 0 0", key_drop, entry_value, entry_digits); end
        key_up();
        ev_ready = 1'b1;
        tick();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL clr_drained got %0b want 0", ev_valid); end
    endtask

    task automatic test_async_reset();
        ev_ready = 1'b1;
        press(9); press(9);
        n_cmp++; if (entry_value !== 16'd99) begin n_bad++; $display("FAIL ar_entry got %0d want 99", entry_value); end
        ev_ready = 1'b0;
        key_down(13); key_up();
        press(9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (ev_valid !== 1'b0 || ev_value !== 16'd0 || ev_kind !== 2'd0 || ev_op !== 2'd0) begin
            n_bad++; $display("FAIL ar_event got v=%0b val=%0h k=%0d op=%0d want 0 0 0 0", ev_valid, ev_value, ev_kind, ev_op); end
        n_cmp++; if (entry_value !== 16'd0 || entry_digits !== 3'd0 || entry_neg !== 1'b0) begin
            n_bad++; $display("FAIL ar_entry_zero got %0h/%0d/%0b want 0/0/0", entry_value, entry_digits, entry_neg); end
        @(negedge clk);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        press(5);
        key_down(15);
        n_cmp++; if (ev_valid !== 1'b1 || ev_value !== 16'd5 || ev_has_operand !== 1'b1) begin n_bad++; $display("FAIL ar_after got v=%0b val=%0d has=%0b want 1 5 1", ev_valid, ev_value, ev_has_operand); end
        key_up();
    endtask

    task automatic test_random();
        logic [15:0] exp_entry, exp_val;
        int r;
        for (int cyc = 0; cyc < 600; cyc++) begin
            keystrobe = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 19);
            if (r < 10) keycode = 4'(r);
            else if (r == 10) keycode = 4'd10;
            else if (r < 13) keycode = 4'd11;
            else keycode = 4'(12 + (r - 13) % 4);
            ev_ready = ($urandom_range(0, 3) != 0);
            tick();
            exp_entry = 16'(m_minus ? -model_mag() : model_mag());
            exp_val = 16'(m_val);
            n_cmp++; if (entry_value !== exp_entry) begin n_bad++; $display("FAIL rnd_entry_value cyc %0d got %0h want %0h", cyc, entry_value, exp_entry); end
            n_cmp++; if (entry_digits !== 3'(m_digs.size()) || entry_neg !== m_minus) begin
                n_bad++; $display("FAIL rnd_entry_state cyc %0d got dig=%0d neg=%0b want %0d %0b", cyc, entry_digits, entry_neg, m_digs.size(), m_minus); end
            n_cmp++; if (ev_valid !== m_pend || key_drop !== m_drop) begin
                n_bad++; $display("FAIL rnd_valid_drop cyc %0d got v=%0b d=%0b want %0b %0b", cyc, ev_valid, key_drop, m_pend, m_drop); end
            if (m_pend) begin
                n_cmp++; if (ev_kind !== 2'(m_kind) || ev_op !== 2'(m_op) || ev_has_operand !== m_has || ev_value !== exp_val) begin
                    n_bad++; $display("FAIL rnd_payload cyc %0d got k=%0d op=%0d has=%0b val=%0h want %0d %0d %0b %0h",
                                      cyc, ev_kind, ev_op, ev_has_operand, ev_value, m_kind, m_op, m_has, exp_val); end
            end
        end
        keystrobe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_negative();
        test_saturate();
        test_backpressure();
        test_clear_override();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
